// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and the alignment rule for the MEM-stage data memory.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef logic [0:0] state_t;
   localparam state_t ST_CLEAR = 1'b0;
   localparam state_t ST_READY = 1'b1;

   // Size 3 is reserved and always rejected.
   function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] lane);
      logic ok;
      case (sz)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = ~lane[0];
         SZ_WORD: ok = (lane == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables / replicated data, load extract / extend.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_lane,
   input  logic        i_sign_ext,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be_c,
   output logic [31:0] o_wdata_c,
   output logic [31:0] o_rdata_c
);

   logic [31:0] w_shift;

   assign w_shift = i_rword >> {i_lane, 3'b000};

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      o_be_c    = 4'b0000;
      o_wdata_c = i_wdata;
      case (i_size)
         SZ_BYTE: begin
            o_be_c    = 4'b0001 << i_lane;
            o_wdata_c = {4{i_wdata[7:0]}};
         end
         SZ_HALF: begin
            o_be_c    = i_lane[1] ? 4'b1100 : 4'b0011;
            o_wdata_c = {2{i_wdata[15:0]}};
         end
         SZ_WORD: o_be_c = 4'b1111;
         default: o_be_c = 4'b0000;
      endcase
   end

   always_comb begin
      o_rdata_c = i_rword;
      case (i_size)
         SZ_BYTE: o_rdata_c = {{24{i_sign_ext & w_shift[7]}},  w_shift[7:0]};
         SZ_HALF: o_rdata_c = {{16{i_sign_ext & w_shift[15]}}, w_shift[15:0]};
         default: o_rdata_c = i_rword;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: byte/half/word access, 1-cycle registered loads,
// read-first on simultaneous access, and a post-reset zeroing sweep.
module data_mem_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH          = 64,
   parameter int unsigned ADDR_W         = 8,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              res,
   input  logic              memwr,
   input  logic              memrd,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       data,
   output logic [31:0]       datao,
   output logic              rvalid,
   output logic              misalign,
   output logic              busy
);

   localparam int unsigned IDX_W    = ADDR_W - 2;
   localparam state_t      ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

   logic [31:0]      r_mem [DEPTH];
   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_cnt;
   logic [IDX_W-1:0] w_cnt_nxt;
   logic             r_busy;
   logic [31:0]      r_datao;
   logic             r_rvalid;
   logic             r_misalign;

   logic [IDX_W-1:0] w_idx;
   logic [1:0]       w_lane;
   logic             w_ready;
   logic             w_legal;
   logic             w_do_rd;
   logic             w_do_wr;
   logic             w_clr_we;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [31:0]      w_rword;
   logic [31:0]      w_rdata;

   assign w_idx    = address[ADDR_W-1:2];
   assign w_lane   = address[1:0];
   assign w_ready  = (r_state == ST_READY);
   assign w_legal  = is_aligned(size, w_lane);
   assign w_do_rd  = w_ready & memrd & w_legal;
   // Array writes are gated by res so reset itself never disturbs contents.
   assign w_do_wr  = res & w_ready & memwr & w_legal;
   assign w_clr_we = res & (r_state == ST_CLEAR);
   assign w_rword  = r_mem[w_idx];

   mem_lane_align u_lane (
      .i_size     (size),
      .i_lane     (w_lane),
      .i_sign_ext (sign_ext),
      .i_wdata    (data),
      .i_rword    (w_rword),
      .o_be_c     (w_be),
      .o_wdata_c  (w_wdata),
      .o_rdata_c  (w_rdata)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_CLEAR: begin
            w_cnt_nxt = r_cnt + IDX_W'(1);
            if (r_cnt == IDX_W'(DEPTH - 1)) begin
               w_state_nxt = ST_READY;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_state <= ST_RESET;
         r_cnt   <= '0;
         r_busy  <= CLEAR_ON_RESET;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_state_nxt == ST_CLEAR);
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_datao    <= '0;
         r_rvalid   <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_rvalid   <= w_do_rd;
         r_misalign <= w_ready & (memrd | memwr) & ~w_legal;
         if (w_do_rd) begin
            r_datao <= w_rdata;
         end
      end
   end

   // Array has no reset; the sweep provides the zero state.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_cnt] <= '0;
      end else if (w_do_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
         end
      end
   end

   assign datao    = r_datao;
   assign rvalid   = r_rvalid;
   assign misalign = r_misalign;
   assign busy     = r_busy;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (DEPTH=64, ADDR_W=8, CLEAR_ON_RESET=1).
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic        memwr = 1'b0;
   logic        memrd = 1'b0;
   logic [1:0]  size = 2'd0;
   logic        sign_ext = 1'b0;
   logic [7:0]  address = 8'h00;
   logic [31:0] data = 32'h0;
   logic [31:0] datao;
   logic        rvalid;
   logic        misalign;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   data_mem_ctrl #(.DEPTH(64), .ADDR_W(8), .CLEAR_ON_RESET(1'b1)) dut (
      .clk      (clk),
      .res      (res),
      .memwr    (memwr),
      .memrd    (memrd),
      .size     (size),
      .sign_ext (sign_ext),
      .address  (address),
      .data     (data),
      .datao    (datao),
      .rvalid   (rvalid),
      .misalign (misalign),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Tasks start and end on a falling edge; the request is presented for one rising edge.
   task automatic do_store(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] d);
      memwr = 1'b1; memrd = 1'b0; address = a; size = sz; data = d;
      @(negedge clk);
      memwr = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] a, input logic [1:0] sz, input logic sx);
      memrd = 1'b1; memwr = 1'b0; address = a; size = sz; sign_ext = sx;
      @(negedge clk);
      memrd = 1'b0;
   endtask

   task automatic count_sweep(output int cycles, output logic saw_rv);
      cycles = 0; saw_rv = 1'b0;
      while (busy && cycles < 200) begin
         cycles++;
         @(negedge clk);
         if (rvalid) saw_rv = 1'b1;
      end
   endtask

   task automatic test_reset();
      int   cycles;
      logic saw_rv;
      logic [7:0] addrs [3];
      addrs[0] = 8'h00; addrs[1] = 8'h7C; addrs[2] = 8'hFC;
      res = 1'b0;
      #2;
      n_total++; if (datao !== 32'h0) $display("FAIL reset_datao: got %h want %h", datao, 32'h0); else n_pass++;
      n_total++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", rvalid); else n_pass++;
      n_total++; if (misalign !== 1'b0) $display("FAIL reset_misalign: got %b want 0", misalign); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
      @(negedge clk);
      res = 1'b1; memrd = 1'b1; size = 2'd2; address = 8'h00;
      count_sweep(cycles, saw_rv);
      memrd = 1'b0;
      n_total++; if (cycles !== 64) $display("FAIL sweep_len: got %0d want 64", cycles); else n_pass++;
      n_total++; if (saw_rv !== 1'b0) $display("FAIL sweep_rd_ignored: rvalid seen %b want 0", saw_rv); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         do_load(addrs[i], 2'd2, 1'b0);
         n_total++;
         if (datao !== 32'h0 || rvalid !== 1'b1)
            $display("FAIL zero_after_sweep @%h: got %h rv=%b want 00000000 rv=1", addrs[i], datao, rvalid);
         else n_pass++;
      end
   endtask

   task automatic test_byte_load();
      do_store(8'h10, 2'd2, 32'hDEADBEEF);
      do_load(8'h13, 2'd0, 1'b1);
      n_total++; if (datao !== 32'hFFFFFFDE || rvalid !== 1'b1) $display("FAIL lb_sx: got %h rv=%b want ffffffde rv=1", datao, rvalid); else n_pass++;
      @(negedge clk);
      n_total++; if (rvalid !== 1'b0 || datao !== 32'hFFFFFFDE) $display("FAIL lb_single_pulse: rv=%b datao=%h want rv=0 ffffffde", rvalid, datao); else n_pass++;
      do_load(8'h13, 2'd0, 1'b0);
      n_total++; if (datao !== 32'h000000DE) $display("FAIL lbu: got %h want 000000de", datao); else n_pass++;
      do_load(8'h10, 2'd0, 1'b1);
      n_total++; if (datao !== 32'hFFFFFFEF) $display("FAIL lb_lane0: got %h want ffffffef", datao); else n_pass++;
      do_load(8'h10, 2'd1, 1'b0);
      n_total++; if (datao !== 32'h0000BEEF) $display("FAIL lhu_lo: got %h want 0000beef", datao); else n_pass++;
   endtask

   task automatic test_byte_store();
      do_store(8'h11, 2'd0, 32'h0000005A);
      do_load(8'h10, 2'd2, 1'b0);
      n_total++; if (datao !== 32'hDEAD5AEF) $display("FAIL sb_merge: got %h want dead5aef", datao); else n_pass++;
      do_load(8'h12, 2'd1, 1'b1);
      n_total++; if (datao !== 32'hFFFFDEAD) $display("FAIL lh_sx_hi: got %h want ffffdead", datao); else n_pass++;
      do_store(8'h2E, 2'd1, 32'hFFFF8001);
      do_load(8'h2C, 2'd2, 1'b0);
      n_total++; if (datao !== 32'h80010000) $display("FAIL sh_hi: got %h want 80010000", datao); else n_pass++;
   endtask

   task automatic test_misalign();
      do_load(8'h13, 2'd1, 1'b1);
      n_total++; if (misalign !== 1'b1 || rvalid !== 1'b0) $display("FAIL mis_lh: mis=%b rv=%b want mis=1 rv=0", misalign, rvalid); else n_pass++;
      n_total++; if (datao !== 32'h80010000) $display("FAIL mis_hold: got %h want 80010000", datao); else n_pass++;
      @(negedge clk);
      n_total++; if (misalign !== 1'b0) $display("FAIL mis_pulse: got %b want 0", misalign); else n_pass++;
      do_store(8'h22, 2'd2, 32'h11111111);
      n_total++; if (misalign !== 1'b1 || rvalid !== 1'b0) $display("FAIL mis_sw: mis=%b rv=%b want mis=1 rv=0", misalign, rvalid); else n_pass++;
      do_load(8'h20, 2'd2, 1'b0);
      n_total++; if (datao !== 32'h0 || misalign !== 1'b0) $display("FAIL mis_no_write: got %h mis=%b want 00000000 mis=0", datao, misalign); else n_pass++;
      do_load(8'h00, 2'd3, 1'b0);
      n_total++; if (misalign !== 1'b1 || rvalid !== 1'b0) $display("FAIL mis_size3: mis=%b rv=%b want mis=1 rv=0", misalign, rvalid); else n_pass++;
   endtask

   task automatic test_read_first();
      do_store(8'h10, 2'd2, 32'hCAFEF00D);
      memwr = 1'b1; memrd = 1'b1; address = 8'h10; size = 2'd2; data = 32'h12345678; sign_ext = 1'b0;
      @(negedge clk);
      memwr = 1'b0; memrd = 1'b0;
      n_total++; if (datao !== 32'hCAFEF00D || rvalid !== 1'b1) $display("FAIL rw_old: got %h rv=%b want cafef00d rv=1", datao, rvalid); else n_pass++;
      do_load(8'h10, 2'd2, 1'b0);
      n_total++; if (datao !== 32'h12345678) $display("FAIL rw_commit: got %h want 12345678", datao); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0]  a  [3];
      logic [31:0] ex [3];
      a[0] = 8'h30; a[1] = 8'h34; a[2] = 8'h10;
      ex[0] = 32'h01020304; ex[1] = 32'hA5A5A5A5; ex[2] = 32'h12345678;
      do_store(8'h30, 2'd2, 32'h01020304);
      do_store(8'h34, 2'd2, 32'hA5A5A5A5);
      for (int i = 0; i < 3; i++) begin
         do_load(a[i], 2'd2, 1'b0);
         n_total++;
         if (datao !== ex[i] || rvalid !== 1'b1)
            $display("FAIL b2b_load%0d: got %h rv=%b want %h rv=1", i, datao, rvalid, ex[i]);
         else n_pass++;
      end
      do_store(8'h38, 2'd2, 32'h87654321);
      do_load(8'h3B, 2'd0, 1'b1);
      n_total++; if (datao !== 32'hFFFFFF87) $display("FAIL st_then_ld: got %h want ffffff87", datao); else n_pass++;
   endtask

   task automatic test_reset_mid_sweep();
      int   cycles;
      logic saw_rv;
      res = 1'b0;
      #1;
      n_total++; if (datao !== 32'h0 || busy !== 1'b1) $display("FAIL rst_async: datao=%h busy=%b want 00000000 busy=1", datao, busy); else n_pass++;
      @(negedge clk);
      res = 1'b1;
      repeat (30) @(negedge clk);
      n_total++; if (busy !== 1'b1) $display("FAIL mid_sweep_busy: got %b want 1", busy); else n_pass++;
      res = 1'b0;
      #1;
      n_total++;
      if (datao !== 32'h0 || rvalid !== 1'b0 || misalign !== 1'b0 || busy !== 1'b1)
         $display("FAIL rst_mid: datao=%h rv=%b mis=%b busy=%b want 0 0 0 1", datao, rvalid, misalign, busy);
      else n_pass++;
      @(negedge clk);
      res = 1'b1;
      count_sweep(cycles, saw_rv);
      n_total++; if (cycles !== 64) $display("FAIL resweep_len: got %0d want 64", cycles); else n_pass++;
      do_load(8'h10, 2'd2, 1'b0);
      n_total++; if (datao !== 32'h0 || rvalid !== 1'b1) $display("FAIL resweep_zero10: got %h rv=%b want 00000000 rv=1", datao, rvalid); else n_pass++;
      do_load(8'h38, 2'd2, 1'b0);
      n_total++; if (datao !== 32'h0) $display("FAIL resweep_zero38: got %h want 00000000", datao); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_byte_load();
      test_byte_store();
      test_misalign();
      test_read_first();
      test_back_to_back();
      test_reset_mid_sweep();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
